// File: rtl/tlb_entry_array.sv
// Fully-associative Sv32 L0 TLB entry store: PTW refills, SFENCE.VMA flushes and
// one-cycle-latency lookups with megapage PPN splicing and a saturating miss counter.
module tlb_entry_array #(
  parameter int NUM_ENTRIES = 4,
  parameter int MISS_CNT_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [19:0]           req_vpn,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [34:0]           resp_entry,
  input  logic                  refill_valid,
  output logic                  refill_ready,
  input  logic [19:0]           refill_vpn,
  input  logic                  refill_level,
  input  logic [34:0]           refill_entry,
  input  logic                  sfence_valid,
  input  logic                  sfence_rs1,
  input  logic [19:0]           sfence_vpn,
  output logic [MISS_CNT_W-1:0] miss_count
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  logic [NUM_ENTRIES-1:0] valid_reg;
  logic [NUM_ENTRIES-1:0] level_reg;
  logic [19:0]            vpn_reg   [NUM_ENTRIES];
  logic [34:0]            entry_reg [NUM_ENTRIES];
  logic [IDX_W-1:0]       rr_reg;
  logic [MISS_CNT_W-1:0]  miss_reg;
  logic                   resp_valid_reg;
  logic                   resp_hit_reg;
  logic [34:0]            resp_entry_reg;

  logic [NUM_ENTRIES-1:0] lookup_match;
  logic [NUM_ENTRIES-1:0] refill_match;
  logic [NUM_ENTRIES-1:0] sfence_match;

  // A refill duplicates an entry when the two page ranges overlap, whichever is the megapage.
  for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_match
    assign lookup_match[gi] = valid_reg[gi] && (vpn_reg[gi][19:10] == req_vpn[19:10]) &&
                              (level_reg[gi] || (vpn_reg[gi][9:0] == req_vpn[9:0]));
    assign refill_match[gi] = valid_reg[gi] && (vpn_reg[gi][19:10] == refill_vpn[19:10]) &&
                              (level_reg[gi] || refill_level ||
                               (vpn_reg[gi][9:0] == refill_vpn[9:0]));
    assign sfence_match[gi] = valid_reg[gi] && (vpn_reg[gi][19:10] == sfence_vpn[19:10]) &&
                              (level_reg[gi] || (vpn_reg[gi][9:0] == sfence_vpn[9:0]));
  end

  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] dup_idx;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] victim_idx;
  logic             hit;
  logic             dup;
  logic             free;
  logic [34:0]      hit_entry;
  logic             refill_fire;

  always_comb begin
    hit_idx  = '0;
    dup_idx  = '0;
    free_idx = '0;
    // Descending scan so the lowest matching index wins.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (lookup_match[i]) hit_idx = IDX_W'(i);
      if (refill_match[i]) dup_idx = IDX_W'(i);
      if (!valid_reg[i])   free_idx = IDX_W'(i);
    end
    hit  = |lookup_match;
    dup  = |refill_match;
    free = ~&valid_reg;
    victim_idx = dup ? dup_idx : (free ? free_idx : rr_reg);
    hit_entry = entry_reg[hit_idx];
    if (level_reg[hit_idx]) hit_entry[24:15] = req_vpn[9:0];
  end

  assign refill_ready = !reset || !sfence_valid;
  assign refill_fire  = reset && refill_valid && !sfence_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_reg      <= '0;
      level_reg      <= '0;
      rr_reg         <= '0;
      miss_reg       <= '0;
      resp_valid_reg <= 1'b0;
      resp_hit_reg   <= 1'b0;
      resp_entry_reg <= '0;
    end else begin
      resp_valid_reg <= req_valid;
      resp_hit_reg   <= req_valid && hit;
      resp_entry_reg <= (req_valid && hit) ? hit_entry : 35'd0;
      if (req_valid && !hit && (miss_reg != {MISS_CNT_W{1'b1}})) miss_reg <= miss_reg + 1'b1;
      if (sfence_valid) begin
        valid_reg <= sfence_rs1 ? (valid_reg & ~sfence_match) : '0;
      end else if (refill_fire) begin
        valid_reg[victim_idx] <= 1'b1;
        level_reg[victim_idx] <= refill_level;
        if (!dup && !free) rr_reg <= rr_reg + 1'b1;
      end
    end
  end

  // Payload storage needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clock) begin
    if (refill_fire) begin
      vpn_reg[victim_idx]   <= refill_vpn;
      entry_reg[victim_idx] <= refill_entry;
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_hit   = resp_hit_reg;
  assign resp_entry = resp_entry_reg;
  assign miss_count = miss_reg;

endmodule

// File: doc/tlb_entry_array.md
# tlb_entry_array

Four-entry fully-associative L0 TLB entry store for Sv32 translation. Sits directly upstream of the TLB entry optimization barrier: holds PTW refills, answers lookups one cycle later and presents the hit entry fields that the barrier passes on. Supports 4 KiB pages and 4 MiB megapages, and honours SFENCE.VMA, both global and by address.

## Interface
- NUM_ENTRIES, 4: entry count; power of two, 2..8.
- MISS_CNT_W, 16: width of the saturating miss counter.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-low; state clears on a rising clock edge while reset==0.
- req_valid  in  1  lookup request.
- req_vpn  in  20  virtual page number.
- resp_valid  out  1  lookup result valid; one cycle after req_valid.
- resp_hit  out  1  the lookup hit a valid entry.
- resp_entry  out  35  hit entry, packed MSB first: ppn[34:15], u[14], g[13], ae[12], sw[11], sx[10], sr[9], pw[8], px[7], pr[6], ppp[5], pal[4], paa[3], eff[2], c[1], fragmented_superpage[0].
- refill_valid  in  1  PTW refill offered.
- refill_ready  out  1  refill accepted this cycle.
- refill_vpn  in  20  VPN of the refill.
- refill_level  in  1  0 = 4 KiB page, 1 = 4 MiB megapage.
- refill_entry  in  35  entry fields, packed as resp_entry.
- sfence_valid  in  1  flush request.
- sfence_rs1  in  1  0 = flush all, 1 = flush matching sfence_vpn only.
- sfence_vpn  in  20  address for a selective flush.
- miss_count  out  MISS_CNT_W  saturating count of lookup misses.

## Operation
- Per-entry state: valid, level, vpn[19:0], entry[34:0].
- Match rules:
  - Level-0 entry matches when vpn == req_vpn.
  - Level-1 entry matches when vpn[19:10] == req_vpn[19:10].
  - At most one entry matches (see the duplicate rule under Refill).
- Lookup:
  - The match is computed combinationally from array state before this cycle's write.
  - The result is registered into resp_*.
  - Level-1 hit: resp_entry.ppn = {stored ppn[19:10], req_vpn[9:0]}; all other fields are stored as written.
  - Miss: resp_hit=0 and resp_entry=0.
  - miss_count increments on each miss and saturates at all-ones.
- Refill:
  - refill_ready = !sfence_valid, combinational. It is forced high during reset, but no write occurs while reset==0.
  - A transfer occurs when refill_valid && refill_ready. Victim selection:
    - If some valid entry already matches refill_vpn (under either entry's level), overwrite that entry. This is the duplicate rule.
    - Otherwise, take the lowest-index invalid entry.
    - Otherwise, take the entry at rr_ptr, then advance rr_ptr by 1 modulo NUM_ENTRIES.
  - rr_ptr advances only in the last case above.
- Flush:
  - sfence_rs1=0 clears every valid bit.
  - sfence_rs1=1 clears the valid bit of each entry that matches sfence_vpn under the match rules.
  - rr_ptr is unchanged by either flush.
- Priority in one cycle:
  - sfence beats refill, because refill_ready is low.
  - A lookup in the same cycle as a refill or flush sees pre-write state.
  - Lookups are never stalled.

## Timing
- Lookup latency is 1 cycle. resp_valid equals req_valid delayed by 1 cycle. Back-to-back requests give back-to-back responses.
- A refill written at edge N is visible to a lookup presented in cycle N+1. There is no same-cycle bypass.
- A flush at edge N takes effect for lookups from cycle N+1. A lookup presented in the flush cycle still hits the old entry.
- Reset (reset==0 at an edge) sets:
  - resp_valid=0, resp_hit=0, resp_entry=0
  - every valid bit = 0
  - rr_ptr=0
  - miss_count=0
- A reset asserted mid-operation discards any in-flight response; the cycle after reset shows resp_valid=0.
- Full array: replacement is pure round-robin (0,1,2,3,0,...) until a flush creates holes.
- Wrap-around: rr_ptr wraps from NUM_ENTRIES-1 to 0. miss_count holds at 2^MISS_CNT_W-1.

## Test plan
- Refill vpn 0x12345 at level 0 with ppn 0xABCDE and pr=1; look up 0x12345 the next cycle -> one cycle later resp_valid=1, resp_hit=1, resp_entry[34:15]=0xABCDE, resp_entry[6]=1. Look up 0x12346 -> resp_hit=0 and miss_count=1.
- Refill vpn 0x40000 at level 1 with ppn 0x80000; look up 0x403FF -> hit with ppn 0x803FF. Look up 0x40400 -> miss.
- Fill entries with vpns 1 to 4, then refill vpns 5 and 6 -> entries 0 and 1 are replaced (rr_ptr=2); vpn 1 misses and vpn 3 hits. Refill vpn 3 again with a new ppn -> entry 2 is overwritten in place and rr_ptr stays 2.
- Assert refill_valid and sfence_valid (rs1=0) in the same cycle -> refill_ready=0. Every lookup from the next cycle misses. A lookup presented in the flush cycle still hits.
- Selective sfence with rs1=1 and vpn 0x40123 against a level-1 entry 0x40000 and a level-0 entry 0x00007 -> only the megapage is invalidated.
- Force 70000 misses with MISS_CNT_W=16 -> miss_count saturates at 0xFFFF. Pulse reset low mid-stream -> the next cycle shows resp_valid=0 and miss_count=0, and all lookups miss.
